// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grants one requester at a time and
// inserts one enable-low GAP cycle at every change of owner.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    output logic [3:0]    gnt,
    output logic [1:0]    se,
    output logic          en,
    output logic          busy,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_SAT = '1;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    se_q, se_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [1:0]    win;
    logic          any_req;
    logic          owner_req;
    logic          others_pending;
    logic          preempt;
    logic          release_owner;

    // Rotating priority search starting at ptr, wrapping 3 -> 0.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req        = |req;
    assign owner_req      = req[se_q];
    assign others_pending = |(req & ~gnt_q);
    assign preempt        = (MAX_HOLD != 0) && (hold_q == HOLD_LIM) && others_pending;
    // An owner dropping its request and a preemption both end the same way.
    assign release_owner  = !owner_req || preempt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        se_d    = se_q;
        en_d    = en_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (any_req) begin
                    state_d = S_BUSY;
                    gnt_d   = 4'(1) << win;
                    se_d    = win;
                    en_d    = 1'b1;
                    hold_d  = HOLD_ONE;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                    hold_d  = '0;
                end
            end
            S_BUSY: begin
                if (release_owner) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                    hold_d  = '0;
                    ptr_d   = se_q + 2'd1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d  = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                en_d    = 1'b0;
                hold_d  = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            se_q    <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            se_q    <= se_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt      = gnt_q;
    assign se       = se_q;
    assign en       = en_q;
    assign busy     = busy_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: per-cycle expected outputs are queued
// as stimulus is driven and compared after the following clock edge.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CW       = 4;

    typedef struct packed {
        logic [3:0]    gnt;
        logic [1:0]    se;
        logic          en;
        logic          busy;
        logic [CW-1:0] hold;
    } obs_t;

    typedef struct packed {
        logic [3:0] r;
        obs_t       e;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [3:0]    gnt;
    logic [1:0]    se;
    logic          en;
    logic          busy;
    logic [CW-1:0] hold_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .se(se),
        .en(en), .busy(busy), .hold_cnt(hold_cnt)
    );

    function automatic obs_t cur();
        obs_t o;
        o.gnt = gnt; o.se = se; o.en = en; o.busy = busy; o.hold = hold_cnt;
        return o;
    endfunction

    function automatic obs_t mk(logic [3:0] g, logic [1:0] s, logic e, logic b, int h);
        obs_t o;
        o.gnt = g; o.se = s; o.en = e; o.busy = b; o.hold = CW'(h);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("gnt=%b se=%0d en=%b busy=%b hold=%0d", o.gnt, o.se, o.en, o.busy, o.hold);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst = 1'b1; req = 4'b1111;
        tick();
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 0));
        e = sb_q.pop_front(); o = cur(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_held: got %s want %s", fmt(o), fmt(e)); end
        rst = 1'b0; req = '0;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 0));
            tick();
            e = sb_q.pop_front(); o = cur(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset_idle[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_single();
        stim_t st[$];
        obs_t  e, o;
        do_reset();
        st.push_back('{4'b0001, mk(4'b0001, 2'd0, 1'b1, 1'b1, 1)});
        st.push_back('{4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b1, 0)});
        st.push_back('{4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 0)});
        foreach (st[i]) begin
            req = st[i].r;
            sb_q.push_back(st[i].e);
            tick();
            e = sb_q.pop_front(); o = cur(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL single[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_round_robin();
        stim_t      st[$];
        obs_t       e, o;
        logic [3:0] oh;
        logic [1:0] ow;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ow = 2'(k % 4);
            oh = 4'(1) << ow;
            st.push_back('{4'b1111, mk(oh, ow, 1'b1, 1'b1, 1)});
            if (k < 4) begin
                st.push_back('{4'b1111, mk(oh, ow, 1'b1, 1'b1, 2)});
                st.push_back('{4'b1111 & ~oh, mk(4'b0000, ow, 1'b0, 1'b1, 0)});
            end
        end
        foreach (st[i]) begin
            req = st[i].r;
            sb_q.push_back(st[i].e);
            tick();
            e = sb_q.pop_front(); o = cur(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL round_robin[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_preempt();
        stim_t st[$];
        obs_t  e, o;
        do_reset();
        for (int h = 1; h <= 3; h++) st.push_back('{4'b0100, mk(4'b0100, 2'd2, 1'b1, 1'b1, h)});
        for (int h = 4; h <= 8; h++) st.push_back('{4'b0101, mk(4'b0100, 2'd2, 1'b1, 1'b1, h)});
        st.push_back('{4'b0101, mk(4'b0000, 2'd2, 1'b0, 1'b1, 0)});
        for (int h = 1; h <= 8; h++) st.push_back('{4'b0101, mk(4'b0001, 2'd0, 1'b1, 1'b1, h)});
        st.push_back('{4'b0101, mk(4'b0000, 2'd0, 1'b0, 1'b1, 0)});
        st.push_back('{4'b0101, mk(4'b0100, 2'd2, 1'b1, 1'b1, 1)});
        foreach (st[i]) begin
            req = st[i].r;
            sb_q.push_back(st[i].e);
            tick();
            e = sb_q.pop_front(); o = cur(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL preempt[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_saturate();
        obs_t e, o;
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            sb_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b1, (i > 15) ? 15 : i));
            tick();
            e = sb_q.pop_front(); o = cur(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL saturate[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        do_reset();
        req = 4'b1000;
        for (int h = 1; h <= 2; h++) begin
            sb_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b1, h));
            tick();
            e = sb_q.pop_front(); o = cur(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL async_pre[%0d]: got %s want %s", h, fmt(o), fmt(e)); end
        end
        #2 rst = 1'b1;
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 0));
        #1;
        e = sb_q.pop_front(); o = cur(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL async_mid: got %s want %s", fmt(o), fmt(e)); end
        tick();
        rst = 1'b0;
        sb_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b1, 1));
        tick();
        e = sb_q.pop_front(); o = cur(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL async_regrant: got %s want %s", fmt(o), fmt(e)); end
    endtask

    // Continuous invariants, sampled mid-cycle.
    int   last_owner = -1;
    logic gap_seen   = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            last_owner = -1;
            gap_seen   = 1'b0;
        end else begin
            n_cmp++;
            if (!$onehot0(gnt) || (en !== (|gnt)) || (en && (gnt !== (4'b0001 << se)))) begin
                n_err++;
                $display("FAIL invariant: gnt=%b se=%0d en=%b", gnt, se, en);
            end
            if (en) begin
                if (last_owner >= 0 && int'(se) != last_owner) begin
                    n_cmp++;
                    if (!gap_seen) begin
                        n_err++;
                        $display("FAIL no_gap: owner %0d -> %0d, gap_seen=%b want 1", last_owner, se, gap_seen);
                    end
                end
                last_owner = int'(se);
                gap_seen   = 1'b0;
            end else begin
                gap_seen = 1'b1;
            end
        end
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_saturate();
        test_async_reset();
        req = '0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
